// File: rtl/plane_draw_scheduler_pkg.sv
// Shared constants and state encoding for the per-frame plane erase/draw sequencer.
package plane_draw_scheduler_pkg;
  localparam int N_PLANES     = 10;
  localparam int COORD_W      = 8;
  localparam int COLOUR_W     = 3;
  localparam int IDX_W        = $clog2(N_PLANES);
  localparam int PX_W         = 8;
  localparam int PY_W         = 7;
  localparam int SCREEN_W_DEF = 160;
  localparam int SCREEN_H_DEF = 120;

  typedef enum logic [2:0] {IDLE, ERASE, LATCH, DRAW, DONE} state_t;
endpackage

// File: rtl/plane_draw_scheduler_if.sv
// VGA adapter pixel port: one pixel write per clock when plot is high.
interface plane_draw_scheduler_if;
  import plane_draw_scheduler_pkg::*;

  logic [PX_W-1:0]     px;
  logic [PY_W-1:0]     py;
  logic [COLOUR_W-1:0] colour;
  logic                plot;

  modport master (output px, py, colour, plot);
  modport slave  (input  px, py, colour, plot);
endinterface

// File: rtl/plane_draw_scheduler_scan.sv
// Walks planes 0..N_PLANES-1 and the sprite pixels of each visible plane, row-major.
module sprite_scan_counter
  import plane_draw_scheduler_pkg::*;
#(
  parameter  int SPRITE_W = 4,
  parameter  int SPRITE_H = 4,
  localparam int DX_W     = $clog2(SPRITE_W),
  localparam int DY_W     = $clog2(SPRITE_H)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic                run,
  input  logic [N_PLANES-1:0] mask,
  output logic [IDX_W-1:0]    idx,
  output logic [DX_W-1:0]     dx,
  output logic [DY_W-1:0]     dy,
  output logic                pixel_valid,
  output logic                phase_done
);
  localparam int PIX_W = DX_W + DY_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_PLANES - 1);

  logic [PIX_W-1:0] pix;
  logic             plane_end;

  // Invisible planes cost a single skip cycle; visible ones the full sprite.
  assign plane_end   = !mask[idx] || (pix == '1);
  assign pixel_valid = run && mask[idx];
  assign phase_done  = run && (idx == LAST_IDX) && plane_end;
  assign dx          = pix[DX_W-1:0];
  assign dy          = pix[PIX_W-1:DX_W];

  always_ff @(posedge clk) begin
    if (!reset_n || start) begin
      idx <= '0;
      pix <= '0;
    end else if (run) begin
      if (plane_end) begin
        pix <= '0;
        idx <= idx + IDX_W'(1);
      end else begin
        pix <= pix + PIX_W'(1);
      end
    end
  end
endmodule

// File: rtl/plane_draw_scheduler.sv
// Per-frame sequencer: erase old sprites, snapshot coordinates, draw, then pulse move_en.
module plane_draw_scheduler
  import plane_draw_scheduler_pkg::*;
#(
  parameter int                  SPRITE_W     = 4,
  parameter int                  SPRITE_H     = 4,
  parameter int                  SCREEN_W     = SCREEN_W_DEF,
  parameter int                  SCREEN_H     = SCREEN_H_DEF,
  parameter logic [COLOUR_W-1:0] BG_COLOUR    = 3'b000,
  parameter logic [COLOUR_W-1:0] PLANE_COLOUR = 3'b111
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        frame_tick,
  input  logic [N_PLANES*COORD_W-1:0] x_bus,
  input  logic [N_PLANES*COORD_W-1:0] y_bus,
  input  logic [N_PLANES-1:0]         vis,
  plane_draw_scheduler_if.master      vga,
  output logic                        busy,
  output logic                        move_en,
  output logic                        overrun
);
  localparam int DX_W  = $clog2(SPRITE_W);
  localparam int DY_W  = $clog2(SPRITE_H);
  localparam int SUM_W = COORD_W + 1;
  localparam logic [SUM_W-1:0] SCR_W = SUM_W'(SCREEN_W);
  localparam logic [SUM_W-1:0] SCR_H = SUM_W'(SCREEN_H);

  state_t                      state;
  logic [N_PLANES*COORD_W-1:0] old_x, old_y;
  logic [N_PLANES-1:0]         old_vis;
  logic                        scan_start, scan_run;
  logic [IDX_W-1:0]            idx;
  logic [DX_W-1:0]             dx;
  logic [DY_W-1:0]             dy;
  logic                        pixel_valid, phase_done;
  logic [COORD_W-1:0]          cur_x, cur_y;
  logic [SUM_W-1:0]            sum_x, sum_y;
  logic                        on_screen;

  sprite_scan_counter #(.SPRITE_W(SPRITE_W), .SPRITE_H(SPRITE_H)) u_scan (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (scan_start),
    .run         (scan_run),
    .mask        (old_vis),
    .idx         (idx),
    .dx          (dx),
    .dy          (dy),
    .pixel_valid (pixel_valid),
    .phase_done  (phase_done)
  );

  always_comb begin
    scan_start = 1'b0;
    scan_run   = 1'b0;
    case (state)
      IDLE:        scan_start = frame_tick;
      LATCH:       scan_start = 1'b1;
      ERASE, DRAW: scan_run   = 1'b1;
      default:     ;
    endcase
  end

  // Both phases read the snapshot; LATCH refreshes it between erase and draw.
  assign cur_x     = old_x[idx*COORD_W +: COORD_W];
  assign cur_y     = old_y[idx*COORD_W +: COORD_W];
  assign sum_x     = {1'b0, cur_x} + SUM_W'(dx);
  assign sum_y     = {1'b0, cur_y} + SUM_W'(dy);
  assign on_screen = (sum_x < SCR_W) && (sum_y < SCR_H);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      vga.plot   <= 1'b0;
      vga.px     <= '0;
      vga.py     <= '0;
      vga.colour <= '0;
      move_en    <= 1'b0;
      busy       <= 1'b0;
      overrun    <= 1'b0;
      old_x      <= '0;
      old_y      <= '0;
      old_vis    <= '0;
    end else begin
      vga.plot <= 1'b0;
      move_en  <= 1'b0;
      if (frame_tick && state != IDLE) overrun <= 1'b1;
      case (state)
        IDLE: begin
          if (frame_tick) begin
            state <= ERASE;
            busy  <= 1'b1;
          end
        end
        ERASE, DRAW: begin
          if (pixel_valid && on_screen) begin
            vga.plot   <= 1'b1;
            vga.px     <= sum_x[PX_W-1:0];
            vga.py     <= sum_y[PY_W-1:0];
            vga.colour <= (state == ERASE) ? BG_COLOUR : PLANE_COLOUR;
          end
          if (phase_done) state <= (state == ERASE) ? LATCH : DONE;
        end
        LATCH: begin
          old_x   <= x_bus;
          old_y   <= y_bus;
          old_vis <= vis;
          state   <= DRAW;
        end
        DONE: begin
          move_en <= 1'b1;
          busy    <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_plane_draw_scheduler.sv
// Scoreboard bench: expected pixels are queued per frame and popped as the DUT plots them.
module tb_plane_draw_scheduler;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        frame_tick = 1'b0;
  logic [79:0] x_bus = '0;
  logic [79:0] y_bus = '0;
  logic [9:0]  vis = '0;
  logic        busy, move_en, overrun;

  plane_draw_scheduler_if vga ();

  plane_draw_scheduler #(
    .SPRITE_W(4), .SPRITE_H(4), .SCREEN_W(160), .SCREEN_H(120),
    .BG_COLOUR(3'b000), .PLANE_COLOUR(3'b111)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .frame_tick (frame_tick),
    .x_bus      (x_bus),
    .y_bus      (y_bus),
    .vis        (vis),
    .vga        (vga),
    .busy       (busy),
    .move_en    (move_en),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0, errors = 0;
  int cyc = 0, tick_cyc = 0, first_plot_cyc = -1, plot_cnt = 0, move_cnt = 0;
  int px_x[10], px_y[10], ox[10], oy[10];
  logic [9:0] nvis = '0, ovis = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // Scoreboard consumer
  always @(negedge clk) begin
    if (vga.plot === 1'b1) begin
      plot_cnt++;
      if (first_plot_cyc < 0) first_plot_cyc = cyc;
      if (exp_q.size() == 0) check("unexpected_plot", 32'd1, 32'd0);
      else begin
        exp_t e;
        e = exp_q.pop_front();
        check("px", 32'(vga.px), 32'(e.x));
        check("py", 32'(vga.py), 32'(e.y));
        check("colour", 32'(vga.colour), 32'(e.c));
      end
    end
    if (move_en === 1'b1) move_cnt++;
  end

  function automatic int push_phase(input logic [9:0] v, input int xs[10], input int ys[10],
                                    input logic [2:0] c);
    int cycles = 0;
    for (int i = 0; i < 10; i++) begin
      if (v[i]) begin
        cycles += 16;
        for (int k = 0; k < 16; k++) begin
          int x, y;
          exp_t e;
          x = xs[i] + k % 4;
          y = ys[i] + k / 4;
          if (x < 160 && y < 120) begin
            e.x = 8'(x); e.y = 7'(y); e.c = c;
            exp_q.push_back(e);
          end
        end
      end else cycles += 1;
    end
    return cycles;
  endfunction

  task automatic drive_inputs();
    for (int i = 0; i < 10; i++) begin
      x_bus[i*8 +: 8] = 8'(px_x[i]);
      y_bus[i*8 +: 8] = 8'(px_y[i]);
    end
    vis = nvis;
  endtask

  task automatic run_frame(input string tag, input int ovr_at, input int exp_first);
    int len, k, busy_bad, mv0, n_exp;
    drive_inputs();
    len = push_phase(ovis, ox, oy, 3'b000);
    len += 1 + push_phase(nvis, px_x, px_y, 3'b111) + 1;
    n_exp = exp_q.size();
    ox = px_x; oy = px_y; ovis = nvis;
    plot_cnt = 0; first_plot_cyc = -1; mv0 = move_cnt; busy_bad = 0; k = 0;
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    tick_cyc = cyc;
    while (move_en !== 1'b1 && k < 2000) begin
      if (busy !== 1'b1) busy_bad++;
      frame_tick = (k == ovr_at);
      @(negedge clk);
      k++;
    end
    frame_tick = 1'b0;
    if (k >= 2000) check({tag, "_timeout"}, 32'd1, 32'd0);
    check({tag, "_len"}, 32'(k), 32'(len));
    if (exp_first >= 0) check({tag, "_first_plot"}, 32'(first_plot_cyc - tick_cyc), 32'(exp_first));
    check({tag, "_busy_high"}, 32'(busy_bad), 32'd0);
    @(negedge clk);
    check({tag, "_move_en_one_cycle"}, 32'(move_en), 32'd0);
    check({tag, "_busy_low"}, 32'(busy), 32'd0);
    @(negedge clk);
    check({tag, "_move_pulses"}, 32'(move_cnt - mv0), 32'd1);
    check({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_plot_count"}, 32'(plot_cnt), 32'(n_exp));
  endtask

  initial begin
    for (int i = 0; i < 10; i++) begin
      px_x[i] = 0; px_y[i] = 0; ox[i] = 0; oy[i] = 0;
    end
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_plot", 32'(vga.plot), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_move_en", 32'(move_en), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_px", 32'(vga.px), 32'd0);
    check("rst_py", 32'(vga.py), 32'd0);
    check("rst_colour", 32'(vga.colour), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // A: first frame, single plane, nothing to erase
    nvis = 10'b0000000001; px_x[0] = 10; px_y[0] = 20;
    run_frame("A", -1, 12);
    // B: plane moved down one row
    px_y[0] = 21;
    run_frame("B", -1, 1);
    // C: plane 3 at bottom-right corner, mostly clipped
    nvis = 10'b0000001000; px_x[3] = 158; px_y[3] = 118;
    run_frame("C", -1, -1);
    check("C_overrun", 32'(overrun), 32'd0);
    // D: all planes, frame_tick injected mid-DRAW
    nvis = '1;
    for (int i = 0; i < 10; i++) begin
      px_x[i] = 15 * i + 3; px_y[i] = 11 * i + 1;
    end
    run_frame("D", 100, -1);
    check("D_overrun", 32'(overrun), 32'd1);
    // E: all planes steady state
    run_frame("E", -1, 1);
    check("E_overrun_sticky", 32'(overrun), 32'd1);

    // F: reset during ERASE
    drive_inputs();
    void'(push_phase(ovis, ox, oy, 3'b000));
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    repeat (5) @(negedge clk);
    check("F_busy_before_reset", 32'(busy), 32'd1);
    reset_n = 1'b0;
    @(negedge clk);
    check("F_rst_plot", 32'(vga.plot), 32'd0);
    check("F_rst_busy", 32'(busy), 32'd0);
    check("F_rst_overrun", 32'(overrun), 32'd0);
    check("F_rst_move_en", 32'(move_en), 32'd0);
    exp_q.delete();
    reset_n = 1'b1;
    ovis = '0;
    for (int i = 0; i < 10; i++) begin
      ox[i] = 0; oy[i] = 0;
    end
    repeat (3) @(negedge clk);
    check("F_no_plot_after_reset", 32'(vga.plot), 32'd0);

    // G: after reset, nothing erased
    nvis = 10'b0000000001; px_x[0] = 30; px_y[0] = 40;
    run_frame("G", -1, 12);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
